hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Tracks register writes still owed by long-latency producers (loads, mul/div) that issued from decode and have not yet written back. It is the producer-side counterpart of the WB forwarding unit: forwarding covers a result present at writeback, and this block stalls decode while a needed result is still outstanding. It sits between decode/issue and the long-latency writeback port, and drives the decode stall.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: maximum in-flight long-latency ops (≥1).
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_opcode  input  7  decode-stage opcode (OPCODE_* package constants).
- i_rs1  input  5  decode-stage rs1.
- i_rs2  input  5  decode-stage rs2.
- i_issue_valid  input  1  decode holds a valid instruction attempting to issue.
- i_issue_long  input  1  that instruction is a long-latency producer.
- i_issue_rd  input  5  destination of the issuing instruction.
- i_flush  input  1  decode instruction is squashed this cycle.
- i_wb_valid  input  1  a long-latency op writes back this cycle (exactly one per accepted long issue, including rd=x0).
- i_wb_rd  input  5  destination of that writeback.
- o_stall  output  1  hold decode this cycle.
- o_pending  output  32  per-register pending bits (bit 0 always 0).
- o_outstanding  output  CNT_W  in-flight long-op count.
- o_err  output  1  sticky protocol-error flag.

## Operation
- Operand use (same gating as forwarding):
  - rs1 is used unless opcode ∈ {OPCODE_JAL, OPCODE_LUI, OPCODE_AUIPC}.
  - rs2 is used only for opcode ∈ {OPCODE_R, OPCODE_STORE, OPCODE_BRANCH}.
- clr_hit(r) = i_wb_valid && i_wb_rd==r && r!=0. A same-cycle writeback counts as resolved, because WB forwarding supplies the value.
- busy(r) = pending[r] && !clr_hit(r).
- o_stall = i_issue_valid && !i_flush && any of:
  - RAW: rs1 used && busy(rs1).
  - RAW: rs2 used && busy(rs2).
  - WAW: i_issue_long && busy(i_issue_rd).
  - Capacity: i_issue_long && o_outstanding==MAX_OUTSTANDING && !i_wb_valid.
- Accept = i_issue_valid && i_issue_long && !i_flush && !o_stall.
- Pending update each cycle:
  - Clear pending[i_wb_rd] on clr_hit.
  - On accept with i_issue_rd!=0, set pending[i_issue_rd].
  - If set and clear target the same register, set wins.
  - x0 is never set.
- Counter: +1 on accept, −1 on i_wb_valid, unchanged if both occur. It saturates at 0 and at MAX_OUTSTANDING.
- o_err is set, and stays set until reset, if either:
  - i_wb_valid arrives with count 0 (the counter stays at 0), or
  - i_wb_valid with i_wb_rd!=0 targets a register whose pending bit is 0.
- Flush:
  - Blocks only the current decode instruction.
  - Already-accepted ops remain pending and must still write back.
- Non-long instructions never modify state.

## Timing
- Reset (asynchronous assert, synchronous-edge release): pending=0, o_outstanding=0, o_err=0. o_stall therefore evaluates to 0 out of reset.
- o_stall is combinational from registered state plus the current decode and writeback inputs. There is no registered-output latency.
- Pending/counter updates are visible the cycle after accept or writeback.
- Back-to-back long issues to different rd are accepted every cycle until capacity is reached.
- Reset mid-operation drops all in-flight tracking. Writebacks arriving after reset for pre-reset ops set o_err and are otherwise ignored.

## Test plan
- **Load-use stall:**
  - Stimulus: accept long issue rd=5, then present ADD (OPCODE_R) rs1=5 for 3 cycles, with wb rd=5 in the 3rd cycle.
  - Required: o_stall=1,1,0; pending[5] clears the next cycle.
- **Opcode gating:**
  - Stimulus: with pending[7]=1, present LUI rs1=7, then ADDI rs2=7.
  - Required: o_stall=0 for both.
  - Stimulus: STORE rs2=7.
  - Required: o_stall=1.
- **WAW and same-cycle set/clear:**
  - Stimulus: pending[3]=1; issue long rd=3 while wb rd=3 in the same cycle.
  - Required: o_stall=0, pending[3] stays 1, o_outstanding unchanged.
- **Capacity:**
  - Stimulus: MAX_OUTSTANDING=4; accept 4 long ops to x1–x4, then a long issue to rd=6.
  - Required: o_stall=1 and o_outstanding=4.
  - Stimulus: repeat the rd=6 issue with a simultaneous wb rd=1.
  - Required: accepted, o_outstanding stays 4.
- **x0 and flush:**
  - Stimulus: long issue rd=0.
  - Required: pending unchanged, count +1; the later wb rd=0 decrements the count with no error.
  - Stimulus: long issue rd=9 with i_flush=1.
  - Required: no state change.
- **Error and reset:**
  - Stimulus: wb with count 0.
  - Required: o_err=1, count stays 0.
  - Stimulus: assert i_rst_n=0 asynchronously mid-cycle with pending bits set.
  - Required: all outputs are 0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-side scoreboard for long-latency producers: tracks owed register writes
// and an in-flight count, and stalls decode on RAW, WAW or capacity hazards.
module hazard_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic             i_issue_valid,
  input  logic             i_issue_long,
  input  logic [4:0]       i_issue_rd,
  input  logic             i_flush,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  output logic             o_stall,
  output logic [31:0]      o_pending,
  output logic [CNT_W-1:0] o_outstanding,
  output logic             o_err
);

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic        rs1_used, rs2_used;
  logic [31:0] clr_vec, busy_vec;
  logic        raw1, raw2, waw, full;
  logic        stall, accept;

  // A writeback landing this cycle is forwarded, so it no longer blocks decode.
  always_comb begin
    rs1_used = !((i_opcode == OPCODE_JAL) || (i_opcode == OPCODE_LUI) ||
                 (i_opcode == OPCODE_AUIPC));
    rs2_used = (i_opcode == OPCODE_R) || (i_opcode == OPCODE_STORE) ||
               (i_opcode == OPCODE_BRANCH);

    clr_vec = '0;
    if (i_wb_valid && (i_wb_rd != 5'd0)) clr_vec[i_wb_rd] = 1'b1;
    busy_vec = pend_q & ~clr_vec;

    raw1   = rs1_used && busy_vec[i_rs1];
    raw2   = rs2_used && busy_vec[i_rs2];
    waw    = i_issue_long && busy_vec[i_issue_rd];
    full   = i_issue_long && (cnt_q == MAX_CNT) && !i_wb_valid;
    stall  = i_issue_valid && !i_flush && (raw1 || raw2 || waw || full);
    accept = i_issue_valid && i_issue_long && !i_flush && !stall;
  end

  // Set is applied after clear so a same-register set/clear leaves the bit set.
  always_comb begin
    pend_d = pend_q & ~clr_vec;
    if (accept && (i_issue_rd != 5'd0)) pend_d[i_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (accept && !i_wb_valid && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (i_wb_valid && !accept && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    err_d = err_q;
    if (i_wb_valid && ((cnt_q == '0) || ((i_wb_rd != 5'd0) && !pend_q[i_wb_rd]))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign o_stall       = stall;
  assign o_pending     = pend_q;
  assign o_outstanding = cnt_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios followed by random traffic,
// all compared against a register-set/list reference model.
module tb_hazard_scoreboard;

  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [6:0]    i_opcode;
  logic [4:0]    i_rs1, i_rs2, i_issue_rd, i_wb_rd;
  logic          i_issue_valid, i_issue_long, i_flush, i_wb_valid;
  logic          o_stall;
  logic [31:0]   o_pending;
  logic [CW-1:0] o_outstanding;
  logic          o_err;

  hazard_scoreboard #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_rs1(i_rs1),
    .i_rs2(i_rs2), .i_issue_valid(i_issue_valid), .i_issue_long(i_issue_long),
    .i_issue_rd(i_issue_rd), .i_flush(i_flush), .i_wb_valid(i_wb_valid),
    .i_wb_rd(i_wb_rd), .o_stall(o_stall), .o_pending(o_pending),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: set of owed registers, list of in-flight destinations.
  bit  m_pend[32];
  int  m_cnt;
  bit  m_err;
  int  inflight[$];
  int  passed = 0;
  int  total  = 0;
  logic last_stall;

  function automatic bit m_busy(int r);
    return m_pend[r] && !(i_wb_valid && int'(i_wb_rd) == r && r != 0);
  endfunction

  function automatic bit m_stall();
    bit u1, u2, hz;
    u1 = !(i_opcode inside {OP_JAL, OP_LUI, OP_AUIPC});
    u2 = i_opcode inside {OP_R, OP_STORE, OP_BRANCH};
    hz = (u1 && m_busy(int'(i_rs1))) || (u2 && m_busy(int'(i_rs2))) ||
         (i_issue_long && m_busy(int'(i_issue_rd))) ||
         (i_issue_long && m_cnt == MAXO && !i_wb_valid);
    return i_issue_valid && !i_flush && hz;
  endfunction

  function automatic logic [31:0] m_pvec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    inflight.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input bit v, input bit l, input int rd, input logic [6:0] op,
                       input int r1, input int r2, input bit fl, input bit wv, input int wr);
    i_issue_valid = v;  i_issue_long = l;  i_issue_rd = 5'(rd);
    i_opcode = op;      i_rs1 = 5'(r1);    i_rs2 = 5'(r2);
    i_flush = fl;       i_wb_valid = wv;   i_wb_rd = 5'(wr);
  endtask

  // One cycle: check stall before the edge, advance model, check state after.
  task automatic step();
    bit es, acc;
    int k;
    #1;
    es = m_stall();
    last_stall = o_stall;
    chk("stall", 32'(o_stall), 32'(es));
    acc = i_issue_valid && i_issue_long && !i_flush && !es;
    @(posedge i_clk);
    if (i_wb_valid) begin
      if (m_cnt == 0 || (i_wb_rd != 0 && !m_pend[i_wb_rd])) m_err = 1'b1;
      if (i_wb_rd != 0) m_pend[i_wb_rd] = 1'b0;
      k = -1;
      for (int i = 0; i < inflight.size(); i++)
        if (k < 0 && inflight[i] == int'(i_wb_rd)) k = i;
      if (k >= 0) inflight.delete(k);
    end
    if (acc) begin
      if (i_issue_rd != 0) m_pend[i_issue_rd] = 1'b1;
      inflight.push_back(int'(i_issue_rd));
    end
    m_cnt = m_cnt + int'(acc) - int'(i_wb_valid);
    if (m_cnt < 0) m_cnt = 0;
    if (m_cnt > MAXO) m_cnt = MAXO;
    #1;
    chk("pending", o_pending, m_pvec());
    chk("outstanding", 32'(o_outstanding), 32'(m_cnt));
    chk("err", 32'(o_err), 32'(m_err));
  endtask

  task automatic idle();
    drive(0, 0, 0, OP_IMM, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [6:0] ops[8];
    int guard;
    ops = '{OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL};
    i_rst_n = 1'b0;
    idle();
    m_reset();
    #12;
    chk("rst_pending", o_pending, 32'h0);
    chk("rst_outstanding", 32'(o_outstanding), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_stall", 32'(o_stall), 32'h0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Load-use
    drive(1, 1, 5, OP_LOAD, 1, 0, 0, 0, 0); step();
    drive(1, 0, 8, OP_R, 5, 2, 0, 0, 0);    step(); chk("ls_stall1", 32'(last_stall), 32'd1);
    step();                                  chk("ls_stall2", 32'(last_stall), 32'd1);
    drive(1, 0, 8, OP_R, 5, 2, 0, 1, 5);    step(); chk("ls_stall3", 32'(last_stall), 32'd0);
    chk("ls_pend5", 32'(o_pending[5]), 32'd0);

    // Opcode gating
    drive(1, 1, 7, OP_LOAD, 0, 0, 0, 0, 0); step();
    drive(1, 0, 8, OP_LUI, 7, 0, 0, 0, 0);  step(); chk("lui_rs1", 32'(last_stall), 32'd0);
    drive(1, 0, 8, OP_IMM, 0, 7, 0, 0, 0);  step(); chk("addi_rs2", 32'(last_stall), 32'd0);
    drive(1, 0, 8, OP_STORE, 0, 7, 0, 0, 0); step(); chk("store_rs2", 32'(last_stall), 32'd1);
    drive(0, 0, 0, OP_IMM, 0, 0, 0, 1, 7);  step();

    // WAW with same-cycle writeback
    drive(1, 1, 3, OP_LOAD, 0, 0, 0, 0, 0); step();
    drive(1, 1, 3, OP_LOAD, 0, 0, 0, 1, 3); step();
    chk("waw_stall", 32'(last_stall), 32'd0);
    chk("waw_pend3", 32'(o_pending[3]), 32'd1);
    chk("waw_cnt", 32'(o_outstanding), 32'd1);
    drive(0, 0, 0, OP_IMM, 0, 0, 0, 1, 3);  step();

    // Capacity
    for (int r = 1; r <= 4; r++) begin
      drive(1, 1, r, OP_LOAD, 0, 0, 0, 0, 0); step();
    end
    drive(1, 1, 6, OP_LOAD, 0, 0, 0, 0, 0); step();
    chk("cap_stall", 32'(last_stall), 32'd1);
    chk("cap_cnt", 32'(o_outstanding), 32'd4);
    drive(1, 1, 6, OP_LOAD, 0, 0, 0, 1, 1); step();
    chk("cap_accept", 32'(last_stall), 32'd0);
    chk("cap_cnt_hold", 32'(o_outstanding), 32'd4);
    chk("cap_pend6", 32'(o_pending[6]), 32'd1);
    for (int r = 2; r <= 6; r++) begin
      if (r != 5) begin drive(0, 0, 0, OP_IMM, 0, 0, 0, 1, r); step(); end
    end

    // x0 destination and flush
    drive(1, 1, 0, OP_LOAD, 0, 0, 0, 0, 0); step();
    chk("x0_pend", o_pending, 32'h0);
    chk("x0_cnt", 32'(o_outstanding), 32'd1);
    drive(0, 0, 0, OP_IMM, 0, 0, 0, 1, 0);  step();
    chk("x0_wb_cnt", 32'(o_outstanding), 32'd0);
    chk("x0_wb_err", 32'(o_err), 32'd0);
    drive(1, 1, 9, OP_LOAD, 0, 0, 1, 0, 0); step();
    chk("flush_pend", o_pending, 32'h0);
    chk("flush_cnt", 32'(o_outstanding), 32'd0);

    // Random traffic with legal writebacks
    for (int n = 0; n < 400; n++) begin
      bit wv;
      int wr;
      wv = 0; wr = 0;
      if (inflight.size() > 0 && $urandom_range(99) < 45) begin
        wv = 1;
        wr = inflight[$urandom_range(inflight.size() - 1)];
      end
      drive($urandom_range(99) < 80, $urandom_range(1), $urandom_range(7),
            ops[$urandom_range(7)], $urandom_range(7), $urandom_range(7),
            $urandom_range(99) < 10, wv, wr);
      step();
    end
    guard = 0;
    while (inflight.size() > 0 && guard < 64) begin
      drive(0, 0, 0, OP_IMM, 0, 0, 0, 1, inflight[0]); step();
      guard++;
    end
    chk("drain_bound", 32'(inflight.size()), 32'd0);

    // Writeback with nothing outstanding
    drive(0, 0, 0, OP_IMM, 0, 0, 0, 1, 0);  step();
    chk("err_set", 32'(o_err), 32'd1);
    chk("err_cnt0", 32'(o_outstanding), 32'd0);

    // Asynchronous reset mid-cycle with state held
    drive(1, 1, 10, OP_LOAD, 0, 0, 0, 0, 0); step();
    drive(1, 0, 11, OP_R, 10, 10, 0, 0, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_pending", o_pending, 32'h0);
    chk("arst_cnt", 32'(o_outstanding), 32'h0);
    chk("arst_err", 32'(o_err), 32'h0);
    chk("arst_stall", 32'(o_stall), 32'h0);
    #3;
    i_rst_n = 1'b1;
    drive(0, 0, 0, OP_IMM, 0, 0, 0, 1, 10); step();
    chk("post_rst_err", 32'(o_err), 32'd1);
    chk("post_rst_cnt", 32'(o_outstanding), 32'd0);

    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
